// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter.
package uart_tx_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_e;

  localparam int unsigned DEFAULT_DBIT = 8;

  // Ceiling log2 that never returns less than 1, so counters always have a bit
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan rr_ptr..NREQ-1 first, then wrap around to 0..rr_ptr-1
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!gnt_valid && req[j] && (IDX_W'(j) >= rr_ptr)) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
    for (int j = 0; j < int'(NREQ); j++) begin
      if (!gnt_valid && req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serializer among NREQ byte requesters,
// with a post-frame gap and a watchdog that aborts a stuck frame.
// tx_start and ack pulse during the single LAUNCH cycle.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DBIT       = DEFAULT_DBIT,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TIMEOUT    = 200000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DBIT-1:0]    req_data,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         done,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    busy,
  output logic                    timeout_err,
  input  logic                    err_clr,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_data,
  input  logic                    tx_done_tick
);

  localparam int unsigned IDX_W    = clog2_min1(NREQ);
  localparam int unsigned WD_W     = clog2_min1(TIMEOUT);
  localparam int unsigned GAP_W    = clog2_min1(GAP_CYCLES);
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [DBIT-1:0]  data_q, data_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NREQ-1:0]  done_q, done_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (req),
    .rr_ptr    (rr_q),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    wd_d    = wd_q;
    gap_d   = gap_q;
    err_d   = err_q;
    start_d = 1'b0;
    ack_d   = '0;
    done_d  = '0;

    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d           = pick_idx;
          data_d          = req_data[32'(pick_idx) * DBIT +: DBIT];
          start_d         = 1'b1;
          ack_d[pick_idx] = 1'b1;
          state_d         = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        wd_d    = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        wd_d = wd_q + WD_W'(1);
        // A done tick on the expiry cycle still counts as a successful frame
        if (tx_done_tick || (wd_q == WD_W'(TIMEOUT - 1))) begin
          if (tx_done_tick) done_d[gnt_q] = 1'b1;
          else              err_d         = 1'b1;
          rr_d    = (gnt_q == IDX_W'(NREQ - 1)) ? '0 : gnt_q + IDX_W'(1);
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) state_d = ST_IDLE;
        else                           gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      wd_q    <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      wd_q    <= wd_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  assign ack         = ack_q;
  assign done        = done_q;
  assign gnt_id      = gnt_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a frame-level reference model.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DBIT = 8;
  localparam int GAP  = 2;
  localparam int TMO  = 50;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      ack;
  logic [NREQ-1:0]      done;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 timeout_err;
  logic                 err_clr;
  logic                 tx_start;
  logic [DBIT-1:0]      tx_data;
  logic                 tx_done_tick;

  uart_tx_arbiter #(
    .NREQ       (NREQ),
    .DBIT       (DBIT),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_data     (req_data),
    .ack          (ack),
    .done         (done),
    .gnt_id       (gnt_id),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: frame-level view of the arbiter
  bit         in_frame;
  int         start_c, end_c, ready_c, tick_at, ptr, exp_gnt;
  logic [7:0] exp_byte;
  bit         err_exp;
  logic [3:0] req_prev;
  logic [7:0] data_prev [NREQ];
  bit         tick_prev, clr_prev;

  // Requester and serializer-stub state
  bit         pend [NREQ];
  logic [7:0] cur  [NREQ];
  bit         quiet;
  int         n_frames, n_aborts, n_coinc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Round-robin rule: first pending requester starting at the pointer
  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic model_reset();
    in_frame  = 1'b0;
    start_c   = -1000;
    end_c     = -1000;
    ready_c   = 0;
    tick_at   = -1;
    ptr       = 0;
    exp_gnt   = 0;
    exp_byte  = 8'h00;
    err_exp   = 1'b0;
    req_prev  = req;
    for (int i = 0; i < NREQ; i++) data_prev[i] = req_data[i*DBIT +: DBIT];
    tick_prev = tx_done_tick;
    clr_prev  = err_clr;
  endtask

  // One clock: predict, compare, then drive the next cycle's inputs
  task automatic step();
    bit         start_exp, abort, busy_exp, tick_now;
    logic [3:0] ack_exp, done_exp;
    int         r;
    @(posedge clk);
    #1;
    cyc++;
    abort    = 1'b0;
    done_exp = '0;
    ack_exp  = '0;

    // Frame ends on a done tick during BUSY, or after TMO BUSY cycles
    if (in_frame && (cyc - 1) > start_c && (tick_prev || (cyc - 1) == start_c + TMO)) begin
      if (tick_prev) begin
        done_exp[exp_gnt] = 1'b1;
        if ((cyc - 1) == start_c + TMO) n_coinc++;
      end else begin
        abort = 1'b1;
        n_aborts++;
      end
      in_frame = 1'b0;
      end_c    = cyc - 1;
      ready_c  = cyc - 1 + GAP + 2;
      ptr      = (exp_gnt + 1) % NREQ;
    end
    err_exp = abort ? 1'b1 : (clr_prev ? 1'b0 : err_exp);

    start_exp = !in_frame && (cyc >= ready_c) && (req_prev != 4'b0000);
    if (start_exp) begin
      exp_gnt          = pick(req_prev, ptr);
      exp_byte         = data_prev[exp_gnt];
      in_frame         = 1'b1;
      start_c          = cyc;
      ack_exp[exp_gnt] = 1'b1;
      n_frames++;
      r = int'($urandom % 8);
      if (quiet)       tick_at = cyc + 3;
      else if (r == 0) tick_at = -1;
      else if (r == 1) tick_at = cyc + TMO;
      else             tick_at = cyc + int'($urandom_range(1, 12));
    end
    busy_exp = in_frame || (cyc <= end_c + GAP);

    check_eq("tx_start", 32'(tx_start), 32'(start_exp));
    check_eq("ack", 32'(ack), 32'(ack_exp));
    check_eq("done", 32'(done), 32'(done_exp));
    check_eq("busy", 32'(busy), 32'(busy_exp));
    check_eq("timeout_err", 32'(timeout_err), 32'(err_exp));
    if (start_exp) begin
      check_eq("gnt_id", 32'(gnt_id), 32'(exp_gnt));
      check_eq("tx_data_launch", 32'(tx_data), 32'(exp_byte));
    end else if (in_frame) begin
      check_eq("tx_data_hold", 32'(tx_data), 32'(exp_byte));
    end

    // Serializer stub plus stray ticks outside BUSY
    tick_now = in_frame && (cyc == tick_at);
    if ((!in_frame || cyc == start_c) && !quiet && ($urandom % 10 == 0)) tick_now = 1'b1;

    for (int i = 0; i < NREQ; i++) begin
      if (ack_exp[i]) begin
        if (!quiet && ($urandom % 2 == 0)) cur[i] = 8'($urandom);
        else                               pend[i] = 1'b0;
      end else if (!pend[i] && !quiet && ($urandom % 6 == 0)) begin
        pend[i] = 1'b1;
        cur[i]  = 8'($urandom);
      end
      req[i] = pend[i] && (quiet || ($urandom % 16 != 0));
      req_data[i*DBIT +: DBIT] = pend[i] ? cur[i] : 8'($urandom);
    end
    tx_done_tick = tick_now;
    err_clr      = !quiet && ($urandom % 12 == 0);

    req_prev = req;
    for (int i = 0; i < NREQ; i++) data_prev[i] = req_data[i*DBIT +: DBIT];
    tick_prev = tx_done_tick;
    clr_prev  = err_clr;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check_eq({tag, "_gnt_id"}, 32'(gnt_id), 32'd0);
    check_eq({tag, "_tx_data"}, 32'(tx_data), 32'd0);
  endtask

  initial begin
    bit found;
    reset_n      = 1'b0;
    req          = '0;
    req_data     = '0;
    err_clr      = 1'b0;
    tx_done_tick = 1'b0;
    quiet        = 1'b1;
    n_frames     = 0;
    n_aborts     = 0;
    n_coinc      = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      cur[i]  = 8'h00;
    end
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // Single requester 0 with byte A5
    pend[0] = 1'b1;
    cur[0]  = 8'hA5;
    repeat (20) step();
    check_eq("first_byte", 32'(exp_byte), 32'h0000_00A5);

    // All requesters pending with distinct bytes, then random traffic
    quiet = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1;
      cur[i]  = 8'(8'h10 * (i + 1));
    end
    repeat (2500) step();

    // Reset in the middle of a BUSY frame
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (in_frame && cyc >= start_c + 3) found = 1'b1;
    end
    check_eq("busy_frame_found", 32'(found), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    quiet = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    pend[2]      = 1'b1;
    cur[2]       = 8'h3C;
    req          = 4'b0100;
    req_data     = '0;
    req_data[2*DBIT +: DBIT] = 8'h3C;
    tx_done_tick = 1'b0;
    err_clr      = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (20) step();
    check_eq("gnt_after_reset", 32'(gnt_id), 32'd2);
    check_eq("data_after_reset", 32'(tx_data), 32'h0000_003C);

    quiet = 1'b0;
    repeat (600) step();

    check_eq("saw_aborts", 32'(n_aborts > 0), 32'd1);
    check_eq("saw_coincident", 32'(n_coinc > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
